// File: rtl/psum_wb_pack.sv
// psum_wb_pack: write-back packer downstream of psum_wb.
//
// Takes the single-lane signed psum stream and requantizes each psum to a signed
// BIT_OUT activation (round, arithmetic shift, optional ReLU, saturate). It packs
// PACK activations per word, with the first element in the low byte. A small word
// FIFO feeds the activation SRAM through a ready/valid write port that carries an
// auto-incrementing word address. The upstream stream cannot be stalled, so when the
// FIFO is full a push is dropped and the sticky overflow flag is set.
//
// Ports:
//   CLK, RSTn        clock, asynchronous active-low reset
//   i_Start          one-cycle pulse: latch config, clear counters/FIFO/flags, enter RUN
//   i_Shift          right-shift amount (latched on i_Start)
//   i_Relu_En        ReLU enable (latched on i_Start)
//   i_Num_Elems      psums expected this pass (latched on i_Start)
//   i_Data_WB_In     signed psum input
//   i_Valid_WB_In    psum valid
//   o_Wr_Data        FIFO head word
//   o_Wr_Addr        word address of FIFO head
//   o_Wr_Valid       FIFO not empty
//   i_Wr_Ready       SRAM accepts the head word when o_Wr_Valid & i_Wr_Ready
//   o_Busy           pass in progress (state is not IDLE)
//   o_Done           one-cycle pulse at end of pass
//   o_Overflow       sticky: a word was dropped because the FIFO was full
module psum_wb_pack #(
    parameter int unsigned BIT_PSUM   = 32,
    parameter int unsigned BIT_OUT    = 8,
    parameter int unsigned PACK       = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 10
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic                    i_Start,
    input  logic [4:0]              i_Shift,
    input  logic                    i_Relu_En,
    input  logic [ADDR_W+1:0]       i_Num_Elems,
    input  logic [BIT_PSUM-1:0]     i_Data_WB_In,
    input  logic                    i_Valid_WB_In,
    output logic [PACK*BIT_OUT-1:0] o_Wr_Data,
    output logic [ADDR_W-1:0]       o_Wr_Addr,
    output logic                    o_Wr_Valid,
    input  logic                    i_Wr_Ready,
    output logic                    o_Busy,
    output logic                    o_Done,
    output logic                    o_Overflow
);

    localparam int unsigned LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WORD_W = PACK * BIT_OUT;
    localparam int unsigned EXT_W  = BIT_PSUM + 1;
    localparam int unsigned ELEM_W = ADDR_W + 2;

    localparam logic signed [EXT_W-1:0] RND_ONE = 1;
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((1 << (BIT_OUT - 1)) - 1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(-(1 << (BIT_OUT - 1)));

    typedef enum logic [2:0] {StIdle, StRun, StFlush, StDrain, StDone} state_e;

    state_e state_q;
    logic   busy_q, done_q, ovf_q;

    // Latched pass configuration
    logic [4:0]        shift_q;
    logic              relu_q;
    logic [ELEM_W-1:0] num_q;

    // Input acceptance and quantize stage
    logic [ELEM_W-1:0] elem_cnt_q;
    logic              q_valid_q;
    logic [BIT_OUT-1:0] q_byte_q;
    logic [ELEM_W-1:0] q_cnt_q;

    // Packing
    logic [LANE_W-1:0] lane_q;
    logic [WORD_W-1:0] word_q;
    logic [ADDR_W-1:0] addr_q;

    // Word FIFO; the address travels with its word
    logic [WORD_W-1:0] mem_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic                    accept;
    logic signed [EXT_W-1:0] q_ext, q_rnd, q_shd;
    logic [BIT_OUT-1:0]      q_byte_d;
    logic                    pack_en, last_pack, push, push_ok, drop, pop;
    logic [WORD_W-1:0]       pack_word;

    // A start pulse takes priority over anything the old pass would accept.
    assign accept = i_Valid_WB_In && !i_Start && (state_q == StRun) && (elem_cnt_q < num_q);

    // Requantize: round half up, arithmetic shift, optional ReLU, saturate.
    always_comb begin
        q_ext = EXT_W'($signed(i_Data_WB_In));
        q_rnd = q_ext;
        if (shift_q != 5'd0) begin
            q_rnd = q_ext + (RND_ONE <<< (shift_q - 5'd1));
        end
        q_shd = q_rnd >>> shift_q;
        if (relu_q && q_shd[EXT_W-1]) begin
            q_shd = '0;
        end
        if (q_shd > SAT_MAX) begin
            q_byte_d = SAT_MAX[BIT_OUT-1:0];
        end else if (q_shd < SAT_MIN) begin
            q_byte_d = SAT_MIN[BIT_OUT-1:0];
        end else begin
            q_byte_d = q_shd[BIT_OUT-1:0];
        end
    end

    // The final element pushes its word (full or partial) on the same edge it is
    // packed, so FLUSH never holds a pending partial word.
    always_comb begin
        pack_en   = q_valid_q && (state_q == StRun);
        last_pack = pack_en && (q_cnt_q == (num_q - 1'b1));
        push      = pack_en && ((lane_q == LANE_W'(PACK - 1)) || last_pack);
        pop       = (count_q != '0) && i_Wr_Ready;
        // Full plus simultaneous pop frees a slot, so that is not an overflow.
        push_ok   = push && ((count_q != CNT_W'(FIFO_DEPTH)) || pop);
        drop      = push && !push_ok;
        pack_word = word_q;
        for (int l = 0; l < int'(PACK); l++) begin
            if (lane_q == LANE_W'(l)) begin
                pack_word[l*BIT_OUT +: BIT_OUT] = q_byte_q;
            end
        end
    end

    // Control FSM with registered busy/done
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (i_Start) begin
                state_q <= StRun;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    StIdle: ;
                    StRun: begin
                        if ((num_q == '0) || last_pack) begin
                            state_q <= StFlush;
                        end
                    end
                    StFlush: state_q <= StDrain;
                    StDrain: begin
                        // Leave on the last pop so o_Done follows it by one cycle.
                        if ((count_q == '0) || ((count_q == CNT_W'(1)) && pop)) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Config, counters, quantize register and packing
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            shift_q    <= '0;
            relu_q     <= 1'b0;
            num_q      <= '0;
            elem_cnt_q <= '0;
            q_valid_q  <= 1'b0;
            q_byte_q   <= '0;
            q_cnt_q    <= '0;
            lane_q     <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            ovf_q      <= 1'b0;
        end else if (i_Start) begin
            shift_q    <= i_Shift;
            relu_q     <= i_Relu_En;
            num_q      <= i_Num_Elems;
            elem_cnt_q <= '0;
            q_valid_q  <= 1'b0;
            q_cnt_q    <= '0;
            lane_q     <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            q_valid_q <= accept;
            if (accept) begin
                elem_cnt_q <= elem_cnt_q + 1'b1;
                q_byte_q   <= q_byte_d;
            end
            if (pack_en) begin
                q_cnt_q <= q_cnt_q + 1'b1;
                if (push) begin
                    lane_q <= '0;
                    word_q <= '0;
                    // Address advances even on a dropped word.
                    addr_q <= addr_q + 1'b1;
                    if (drop) begin
                        ovf_q <= 1'b1;
                    end
                end else begin
                    lane_q <= lane_q + 1'b1;
                    word_q <= pack_word;
                end
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (i_Start) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push_ok && pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (push_ok && !i_Start) begin
            mem_data[wr_ptr_q] <= pack_word;
            mem_addr[wr_ptr_q] <= addr_q;
        end
    end

    assign o_Wr_Valid = (count_q != '0);
    assign o_Wr_Data  = o_Wr_Valid ? mem_data[rd_ptr_q] : '0;
    assign o_Wr_Addr  = o_Wr_Valid ? mem_addr[rd_ptr_q] : '0;
    assign o_Busy     = busy_q;
    assign o_Done     = done_q;
    assign o_Overflow = ovf_q;

endmodule

// File: doc/psum_wb_pack.md
# psum_wb_pack

Write-back packer directly downstream of `psum_wb`. It consumes the single-lane psum stream (`o_Data_WB_Out` / `o_Valid_WB_Psum`), requantizes each psum to a signed 8-bit activation (round, shift, optional ReLU, saturate), and packs four activations per 32-bit word. A 4-entry FIFO buffers the packed words, which go to the output activation SRAM through a ready/valid write port with an auto-incrementing address. The upstream stream has no backpressure, so FIFO overflow is flagged, never stalled.

## Interface
- `BIT_PSUM`, 32, psum width; must equal the design's `` `BIT_PSUM ``.
- `BIT_OUT`, 8, activation width.
- `PACK`, 4, activations per output word.
- `FIFO_DEPTH`, 4, word FIFO entries (power of 2).
- `ADDR_W`, 10, write address width.
- Clock and reset: one clock; reset is asynchronous and active-low (`CLK`, `RSTn`).
- `CLK` in 1: clock.
- `RSTn` in 1: async active-low reset.
- `i_Start` in 1: one-cycle pulse; latches config, clears counters/FIFO/flags, enters RUN.
- `i_Shift` in 5: right-shift amount, latched on `i_Start`.
- `i_Relu_En` in 1: ReLU enable, latched on `i_Start`.
- `i_Num_Elems` in ADDR_W+2: psums expected this pass, latched on `i_Start`.
- `i_Data_WB_In` in BIT_PSUM: psum from `psum_wb` (signed).
- `i_Valid_WB_In` in 1: psum valid.
- `o_Wr_Data` out PACK*BIT_OUT: FIFO head word; first element in bits [7:0].
- `o_Wr_Addr` out ADDR_W: word address of head.
- `o_Wr_Valid` out 1: FIFO not empty.
- `i_Wr_Ready` in 1: SRAM accepts the word when `o_Wr_Valid & i_Wr_Ready`.
- `o_Busy` out 1: state is not IDLE.
- `o_Done` out 1: one-cycle pulse at end of pass.
- `o_Overflow` out 1: sticky; a word was dropped because the FIFO was full.

## Operation
- States: IDLE, RUN, FLUSH, DRAIN, DONE. IDLE -> RUN on `i_Start`. RUN -> FLUSH when accepted element count == Num_Elems. FLUSH: if lane != 0, push the partial word (unused bytes zero), then go to DRAIN. DRAIN -> DONE when the FIFO is empty and no push is pending. DONE (1 cycle, `o_Done`=1) -> IDLE.
- `i_Start` in any state restarts the pass: FIFO, lane, element, and address counters and `o_Overflow` are cleared and the new config is latched.
- Num_Elems == 0: RUN -> FLUSH -> DRAIN -> DONE with no writes.
- Inputs are accepted only in RUN and only while element count < Num_Elems. Extra or out-of-state valids are ignored and not counted.
- Quantize (stage Q, registered): sign-extend to BIT_PSUM+1 bits. If Shift > 0, add 1<<(Shift-1), then arithmetic shift right by Shift; Shift = 0 passes the value through. If ReLU is enabled, negative results become 0. Saturate to [-128, 127].
- Pack: a lane counter runs 0..PACK-1. On each Q-valid, the byte goes to lane `lane`. When lane == PACK-1, the completed word is pushed and the lane wraps to 0.
- FIFO: push and pop in the same cycle are legal when full; this is not an overflow. A push when full with no pop drops the word and sets `o_Overflow`; the address still advances, so later words keep their correct addresses.
- Address: each pushed word carries an address from a counter that starts at 0 and increments per push attempt. The address travels with the word in the FIFO.

## Timing
- Reset values: `o_Wr_Data`=0, `o_Wr_Addr`=0, `o_Wr_Valid`=0, `o_Busy`=0, `o_Done`=0, `o_Overflow`=0; state = IDLE.
- Psum valid in cycle t -> Q register valid in t+1 -> if it completes a word, `o_Wr_Valid`=1 in t+2.
- RUN -> FLUSH is decided on the last Q-valid. The FLUSH push lands on the same edge as that final element's pack.
- `o_Done` is asserted one cycle after the last FIFO pop.
- Max sustained input rate is 1 psum/cycle. The FIFO absorbs up to FIFO_DEPTH words of `i_Wr_Ready` low.

## Test plan
- Shift=0, ReLU off, 8 psums 1..8 streamed back-to-back, ready=1 -> words 0x04030201 @0 and 0x08070605 @1, then `o_Done`.
- Shift=4, ReLU on, psums {24, -100, 4000, 7} -> bytes {2, 0, 127, 0} -> 0x007F0002 @0.
- Shift=1, psums {-3, 3, -40000, 255}: rounding and saturation -> {-1, 2, -128, 127} -> 0x7F8002FF.
- Num_Elems=6, ready=1 -> word 0 full, word 1 = 0x0000 plus the two bytes (upper bytes zero), `o_Done` after the second write.
- ready held 0 while 24 psums arrive (6 words) -> first 4 words kept, words @4 and @5 dropped, `o_Overflow`=1. Releasing ready drains addresses 0..3, then `o_Done`.
- `i_Start` mid-RUN with 2 words queued -> FIFO empties next cycle, `o_Overflow` clears, new pass addresses restart at 0. Async `RSTn` low mid-pass -> all outputs return to reset values immediately.
